// File: rtl/lsu_axi_bridge.sv
// LSU-to-AXI4 bridge: one single-beat, word-wide AXI transaction per LSU op.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses without bus traffic.
module lsu_axi_bridge #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic [1:0]           rsp_err,
    output logic                 rsp_misalign,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [AddrWidth-1:0] awaddr,
    output logic                 wvalid,
    input  logic                 wready,
    output logic [DataWidth-1:0] wdata,
    output logic [3:0]           wstrb,
    input  logic                 bvalid,
    output logic                 bready,
    input  logic [1:0]           bresp,
    output logic                 arvalid,
    input  logic                 arready,
    output logic [AddrWidth-1:0] araddr,
    input  logic                 rvalid,
    output logic                 rready,
    input  logic [DataWidth-1:0] rdata,
    input  logic [1:0]           rresp
);

    typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB, StRsp} state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic [3:0]             op_q, op_d;
    logic [1:0]             off_q, off_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic [1:0]             err_q, err_d;
    logic                   accept;
    logic                   mis_req;
    logic [7:0]             lb;
    logic [15:0]            lh;
    logic [DataWidth-1:0]   load_ext;

    assign accept = (state_q == StIdle) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;

    assign mis_req = req_op[0] ? req_addr[0]
                   : ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= mis_req;
        end
    end

    assign rsp_misalign = rsp_valid & mis_q;
`else
    assign mis_req      = 1'b0;
    assign rsp_misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            op_q      <= '0;
            off_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            data_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            op_q      <= op_d;
            off_q     <= off_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req_valid) state_d = mis_req ? StRsp : (req_op[3] ? StAwW : StAr);
            StAr:   if (arready) state_d = StR;
            StR:    if (rvalid) state_d = StRsp;
            StAwW:  if ((aw_done_q || awready) && (w_done_q || wready)) state_d = StB;
            StB:    if (bvalid) state_d = StRsp;
            StRsp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Load lane select and extension
    always_comb begin
        unique case (off_q)
            2'd0:    lb = rdata[7:0];
            2'd1:    lb = rdata[15:8];
            2'd2:    lb = rdata[23:16];
            default: lb = rdata[31:24];
        endcase
        lh = off_q[1] ? rdata[31:16] : rdata[15:0];
        if (op_q[1:0] == 2'b10) begin
            load_ext = rdata;
        end else if (op_q[0]) begin
            load_ext = {{16{~op_q[2] & lh[15]}}, lh};
        end else begin
            load_ext = {{24{~op_q[2] & lb[7]}}, lb};
        end
    end

    // Datapath next-state
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        op_d      = op_q;
        off_d     = off_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        data_d    = data_q;
        err_d     = err_q;
        if (accept) begin
            addr_d    = {req_addr[AddrWidth-1:2], 2'b00};
            op_d      = req_op;
            off_d     = req_addr[1:0];
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            data_d    = '0;
            err_d     = 2'b00;
            if (req_op[3]) begin
                if (req_op[1:0] == 2'b10) begin
                    wdata_d = req_wdata;
                    wstrb_d = 4'hF;
                end else if (req_op[0]) begin
                    wdata_d = {2{req_wdata[15:0]}};
                    wstrb_d = req_addr[1] ? 4'b1100 : 4'b0011;
                end else begin
                    wdata_d = {4{req_wdata[7:0]}};
                    wstrb_d = 4'b0001 << req_addr[1:0];
                end
            end
        end
        if (state_q == StAwW) begin
            aw_done_d = aw_done_q | awready;
            w_done_d  = w_done_q | wready;
        end
        // SLVERR/DECERR pass through and blank data; EXOKAY folds to OKAY
        if ((state_q == StR) && rvalid) begin
            err_d  = rresp[1] ? rresp : 2'b00;
            data_d = rresp[1] ? '0 : load_ext;
        end
        if ((state_q == StB) && bvalid) begin
            err_d  = bresp[1] ? bresp : 2'b00;
            data_d = '0;
        end
    end

    // Outputs
    always_comb begin
        req_ready = (state_q == StIdle) && !rst;
        arvalid   = (state_q == StAr);
        rready    = (state_q == StR);
        awvalid   = (state_q == StAwW) && !aw_done_q;
        wvalid    = (state_q == StAwW) && !w_done_q;
        bready    = (state_q == StB);
        rsp_valid = (state_q == StRsp);
        awaddr    = addr_q;
        araddr    = addr_q;
        wdata     = wdata_q;
        wstrb     = wstrb_q;
        rsp_rdata = data_q;
        rsp_err   = err_q;
    end

endmodule
